// File: rtl/pc_control_fsm.sv
// Multicycle MIPS control FSM driving a two-phase PC select stage and datapath strobes.
// Define MIPS_CTRL_BNE_EN to route BNE (000101) down the branch path with branchInvert.
module pc_control_fsm #(
  parameter int STATE_W = 4,
  parameter int OP_W    = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               MemReady,
  output logic               PCwrite,
  output logic               PCwriteCOND,
  output logic [1:0]         PCsource,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRwrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               branchInvert,
  output logic               illegalOp,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH     = STATE_W'(0),
    DECODE    = STATE_W'(1),
    MEM_ADDR  = STATE_W'(2),
    MEM_READ  = STATE_W'(3),
    MEM_WB    = STATE_W'(4),
    MEM_WRITE = STATE_W'(5),
    EXECUTE   = STATE_W'(6),
    R_WB      = STATE_W'(7),
    BRANCH    = STATE_W'(8),
    BR_COMMIT = STATE_W'(9),
    JUMP      = STATE_W'(10),
    J_COMMIT  = STATE_W'(11)
  } state_e;

  localparam logic [OP_W-1:0] OP_R   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J   = OP_W'(6'b000010);
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(6'b000101);
`endif

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
`ifdef MIPS_CTRL_BNE_EN
  logic   bne_q, bne_d;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
`ifdef MIPS_CTRL_BNE_EN
      bne_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
`ifdef MIPS_CTRL_BNE_EN
      bne_q     <= bne_d;
`endif
    end
  end

  // Opcode is only consulted for next-state; the illegal pulse and BNE flag are registered
  always_comb begin
    state_d   = FETCH;
    illegal_d = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
    bne_d     = bne_q;
`endif
    case (state_q)
      FETCH:     state_d = MemReady ? DECODE : FETCH;
      DECODE: begin
`ifdef MIPS_CTRL_BNE_EN
        bne_d = 1'b0;
`endif
        case (opcode)
          OP_R:         state_d = EXECUTE;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE: begin
            state_d = BRANCH;
            bne_d   = 1'b1;
          end
`endif
          default:      illegal_d = 1'b1;
        endcase
      end
      MEM_ADDR:  state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_d = MemReady ? MEM_WB : MEM_READ;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: state_d = MemReady ? FETCH : MEM_WRITE;
      EXECUTE:   state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = BR_COMMIT;
      BR_COMMIT: state_d = FETCH;
      JUMP:      state_d = J_COMMIT;
      J_COMMIT:  state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  // Reset forces every strobe low so an abandoned instruction cannot commit in the reset cycle
  always_comb begin
    PCwrite      = 1'b0;
    PCwriteCOND  = 1'b0;
    PCsource     = 2'b00;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRwrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    branchInvert = 1'b0;
    illegalOp    = illegal_q;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRwrite = MemReady;
      end
      DECODE: begin
        PCwrite = 1'b1;
        ALUSrcB = 2'b11;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH, BR_COMMIT: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCsource    = 2'b01;
        PCwriteCOND = (state_q == BR_COMMIT);
`ifdef MIPS_CTRL_BNE_EN
        branchInvert = bne_q;
`endif
      end
      JUMP:      PCsource = 2'b10;
      J_COMMIT: begin
        PCwrite  = 1'b1;
        PCsource = 2'b10;
      end
      default: ;
    endcase
    if (Reset) begin
      PCwrite      = 1'b0;
      PCwriteCOND  = 1'b0;
      PCsource     = 2'b00;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRwrite      = 1'b0;
      MemtoReg     = 1'b0;
      RegDst       = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      branchInvert = 1'b0;
      illegalOp    = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pc_control_fsm.sv
// Randomized instruction-level bench for pc_control_fsm: each instruction expands into its
// expected per-cycle output sequence, and instruction lengths are checked against literals.
module tb_pc_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rwr;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       binv;
    logic       ill;
  } exp_t;

  typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_J, K_BNE, K_ILL} kind_e;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_BAD = 6'b111111;
`ifdef MIPS_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic       MemReady = 1'b0;
  logic       PCwrite, PCwriteCOND, IorD, MemRead, MemWrite, IRwrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, branchInvert, illegalOp;
  logic [1:0] PCsource, ALUSrcB, ALUOp;
  logic [3:0] state;

  exp_t expQ[$];
  int   expLen[$];
  int   obsLen[$];
  int   assertCount = 0;
  int   failCount = 0;
  int   cycleNo = 0;
  int   prevSt = 15;
  int   runLen = 0;
  bit   started = 1'b0;
  logic pendingIll = 1'b0;

  pc_control_fsm #(.STATE_W(4), .OP_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .opcode(opcode), .MemReady(MemReady),
    .PCwrite(PCwrite), .PCwriteCOND(PCwriteCOND), .PCsource(PCsource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRwrite(IRwrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .branchInvert(branchInvert),
    .illegalOp(illegalOp), .state(state)
  );

  always #5 Clk = ~Clk;

  function automatic exp_t expOut(input int st, input logic mr, input logic inv, input logic ill);
    exp_t e;
    e = '0;
    e.st  = 4'(st);
    e.ill = ill;
    case (st)
      0:  begin e.mrd = 1'b1; e.asb = 2'b01; e.irw = mr; end
      1:  begin e.pcw = 1'b1; e.asb = 2'b11; end
      2:  begin e.asa = 1'b1; e.asb = 2'b10; end
      3:  begin e.mrd = 1'b1; e.iord = 1'b1; end
      4:  begin e.rwr = 1'b1; e.m2r = 1'b1; end
      5:  begin e.mwr = 1'b1; e.iord = 1'b1; end
      6:  begin e.asa = 1'b1; e.aop = 2'b10; end
      7:  begin e.rwr = 1'b1; e.rdst = 1'b1; end
      8:  begin e.asa = 1'b1; e.aop = 2'b01; e.pcs = 2'b01; e.binv = inv; end
      9:  begin e.asa = 1'b1; e.aop = 2'b01; e.pcs = 2'b01; e.binv = inv; e.pcwc = 1'b1; end
      10: begin e.pcs = 2'b10; end
      11: begin e.pcw = 1'b1; e.pcs = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t rstExp(input int st);
    exp_t e;
    e = '0;
    e.st = 4'(st);
    return e;
  endfunction

  function automatic kind_e classify(input logic [5:0] op);
    case (op)
      OP_R:   return K_R;
      OP_LW:  return K_LW;
      OP_SW:  return K_SW;
      OP_BEQ: return K_BEQ;
      OP_J:   return K_J;
      OP_BNE: return BNE_EN ? K_BNE : K_ILL;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic applyStimulus(input logic rst, input logic mr, input logic [5:0] op, input exp_t e);
    @(posedge Clk);
    #1;
    Reset    = rst;
    MemReady = mr;
    opcode   = op;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t a;
    a = {state, PCwrite, PCwriteCOND, PCsource, IorD, MemRead, MemWrite, IRwrite,
         MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, branchInvert, illegalOp};
    assertCount++;
    if (a !== e) begin
      failCount++;
      $display("[TB] FAIL cycle %0d outputs: got state=%0d vec=%h, expected state=%0d vec=%h",
               cycleNo, a.st, a, e.st, e);
    end
  endtask

  task automatic fetchCycle(input logic mr);
    applyStimulus(1'b0, mr, 6'($urandom), expOut(0, mr, 1'b0, pendingIll));
    pendingIll = 1'b0;
  endtask

  task automatic step(input int st, input logic [5:0] op, input logic inv);
    applyStimulus(1'b0, rb(), op, expOut(st, 1'b0, inv, 1'b0));
  endtask

  task automatic runInstr(input logic [5:0] op, input int w0, input int w1);
    kind_e k;
    int    len;
    k   = classify(op);
    len = w0 + 2;
    for (int i = 0; i < w0; i++) fetchCycle(1'b0);
    fetchCycle(1'b1);
    step(1, op, 1'b0);
    case (k)
      K_R:  begin step(6, op, 1'b0); step(7, op, 1'b0); len += 2; end
      K_LW: begin
        step(2, op, 1'b0);
        for (int i = 0; i < w1; i++) applyStimulus(1'b0, 1'b0, op, expOut(3, 1'b0, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b1, op, expOut(3, 1'b1, 1'b0, 1'b0));
        step(4, op, 1'b0);
        len += 3 + w1;
      end
      K_SW: begin
        step(2, op, 1'b0);
        for (int i = 0; i < w1; i++) applyStimulus(1'b0, 1'b0, op, expOut(5, 1'b0, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b1, op, expOut(5, 1'b1, 1'b0, 1'b0));
        len += 2 + w1;
      end
      K_BEQ, K_BNE: begin
        step(8, op, k == K_BNE);
        step(9, op, k == K_BNE);
        len += 2;
      end
      K_J:  begin step(10, op, 1'b0); step(11, op, 1'b0); len += 2; end
      default: pendingIll = 1'b1;
    endcase
    expLen.push_back(len);
  endtask

  // Per-cycle compare plus instruction-length tracking from DUT entries into FETCH
  always @(negedge Clk) begin
    cycleNo++;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
    if (Reset) begin
      started = 1'b0;
      prevSt  = 15;
    end else begin
      if (int'(state) == 0 && prevSt != 0) begin
        if (started) obsLen.push_back(runLen);
        started = 1'b1;
        runLen  = 1;
      end else begin
        runLen++;
      end
      prevSt = int'(state);
    end
  end

  initial begin
    int pins[8];
    int n;
    pins = '{4, 5, 4, 4, 4, 2, (BNE_EN ? 4 : 2), 8};

    applyStimulus(1'b1, 1'b1, OP_R, rstExp(0));
    applyStimulus(1'b1, 1'b1, OP_R, rstExp(0));

    runInstr(OP_R, 0, 0);
    runInstr(OP_LW, 0, 0);
    runInstr(OP_SW, 0, 0);
    runInstr(OP_BEQ, 0, 0);
    runInstr(OP_J, 0, 0);
    runInstr(OP_BAD, 0, 0);
    runInstr(OP_BNE, 0, 0);
    runInstr(OP_LW, 0, 3);

    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      int w0, w1;
      case ($urandom_range(0, 7))
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_BNE;
        6: op = 6'($urandom);
        default: op = OP_BAD;
      endcase
      w0 = (rb()) ? 0 : int'($urandom_range(0, 3));
      w1 = (rb()) ? 0 : int'($urandom_range(0, 3));
      runInstr(op, w0, w1);
    end

    // SW abandoned by a reset during its MEM_WRITE stall
    fetchCycle(1'b1);
    step(1, OP_SW, 1'b0);
    step(2, OP_SW, 1'b0);
    applyStimulus(1'b0, 1'b0, OP_SW, expOut(5, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b1, 1'b0, OP_SW, rstExp(5));
    pendingIll = 1'b0;
    runInstr(OP_R, 0, 0);
    runInstr(OP_J, 1, 0);
    fetchCycle(1'b0);
    @(negedge Clk);
    #1;

    assertCount++;
    if (obsLen.size() != expLen.size()) begin
      failCount++;
      $display("[TB] FAIL length count: got %0d instructions, expected %0d", obsLen.size(), expLen.size());
    end
    n = (obsLen.size() < expLen.size()) ? obsLen.size() : expLen.size();
    for (int i = 0; i < n; i++) begin
      assertCount++;
      if (obsLen[i] != expLen[i]) begin
        failCount++;
        $display("[TB] FAIL instr %0d length: got %0d cycles, expected %0d", i, obsLen[i], expLen[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      assertCount++;
      if (i >= obsLen.size()) begin
        failCount++;
        $display("[TB] FAIL directed %0d length: got none, expected %0d", i, pins[i]);
      end else if (obsLen[i] != pins[i]) begin
        failCount++;
        $display("[TB] FAIL directed %0d length: got %0d cycles, expected %0d", i, obsLen[i], pins[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
